// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational imem read, opcode predecode,
// direct-mapped BTB with 2-bit counters for next-PC prediction, and the IF/ID register.
package id_stage_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        is_conditional_branch;
        logic        is_jalr;
        logic        is_jal;
        logic        predict_taken;
        logic [31:0] predict_pc;
    } id_stage_in_t;
endpackage

module if_stage
    import id_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst,
    output logic [31:0]  imem_addr_o,
    input  logic [31:0]  imem_inst_i,
    input  logic         stall_i,
    input  logic         flush_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    input  logic         upd_en_i,
    input  logic [31:0]  upd_pc_i,
    input  logic [31:0]  upd_target_i,
    input  logic         upd_taken_i,
    input  logic         upd_is_cond_i,
    output id_stage_in_t id_in_o,
    output logic         valid_o
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam id_stage_in_t BUBBLE = '{
        inst:                  NOP_INST,
        pc:                    32'h0,
        pc4:                   32'h0,
        is_conditional_branch: 1'b0,
        is_jalr:               1'b0,
        is_jal:                1'b0,
        predict_taken:         1'b0,
        predict_pc:            32'h0
    };

    logic [31:0] pc;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [31:0]            btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             rd_hit;
    logic             predict_taken;
    logic [31:0]      pc4;
    logic [31:0]      predict_pc;

    assign imem_addr_o = pc;

    assign is_branch = (imem_inst_i[6:0] == OP_BRANCH);
    assign is_jal    = (imem_inst_i[6:0] == OP_JAL);
    assign is_jalr   = (imem_inst_i[6:0] == OP_JALR);

    assign rd_idx = pc[IDX+1:2];
    assign rd_tag = pc[31:IDX+2];
    assign rd_hit = btb_valid[rd_idx] && (btb_tag[rd_idx] == rd_tag);

    // A stale hit on a non-control-flow word must never steer the PC.
    assign predict_taken = rd_hit && (is_jal || is_jalr || (is_branch && btb_ctr[rd_idx][1]));
    assign pc4           = pc + 32'd4;
    assign predict_pc    = predict_taken ? btb_target[rd_idx] : pc4;

    logic [IDX-1:0]   upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             upd_alloc;
    logic             upd_ctr_wr;
    logic             upd_tgt_wr;
    logic [1:0]       upd_ctr_next;
    logic             unused_upd_bits;

    assign upd_idx         = upd_pc_i[IDX+1:2];
    assign upd_tag         = upd_pc_i[31:IDX+2];
    assign upd_hit         = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    assign unused_upd_bits = &{1'b0, upd_pc_i[1:0]};

    always_comb begin
        upd_alloc    = 1'b0;
        upd_ctr_wr   = 1'b0;
        upd_tgt_wr   = 1'b0;
        upd_ctr_next = btb_ctr[upd_idx];
        if (upd_en_i) begin
            if (upd_is_cond_i) begin
                if (upd_hit) begin
                    upd_ctr_wr = 1'b1;
                    upd_tgt_wr = upd_taken_i;
                    if (upd_taken_i)
                        upd_ctr_next = (btb_ctr[upd_idx] == 2'b11) ? 2'b11 : btb_ctr[upd_idx] + 2'd1;
                    else
                        upd_ctr_next = (btb_ctr[upd_idx] == 2'b00) ? 2'b00 : btb_ctr[upd_idx] - 2'd1;
                end else if (upd_taken_i) begin
                    upd_alloc    = 1'b1;
                    upd_ctr_wr   = 1'b1;
                    upd_tgt_wr   = 1'b1;
                    upd_ctr_next = 2'b10;
                end
            end else begin
                upd_alloc    = 1'b1;
                upd_ctr_wr   = 1'b1;
                upd_tgt_wr   = 1'b1;
                upd_ctr_next = 2'b11;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            btb_valid <= '0;
        else if (upd_alloc)
            btb_valid[upd_idx] <= 1'b1;
    end

    // Payload is guarded by the valid bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (upd_alloc)
            btb_tag[upd_idx] <= upd_tag;
        if (upd_ctr_wr)
            btb_ctr[upd_idx] <= upd_ctr_next;
        if (upd_tgt_wr)
            btb_target[upd_idx] <= upd_target_i;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect_i)
            pc <= redirect_pc_i;
        else if (!stall_i)
            pc <= predict_pc;
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            id_in_o <= BUBBLE;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            id_in_o.inst                  <= imem_inst_i;
            id_in_o.pc                    <= pc;
            id_in_o.pc4                   <= pc4;
            id_in_o.is_conditional_branch <= is_branch;
            id_in_o.is_jalr               <= is_jalr;
            id_in_o.is_jal                <= is_jal;
            id_in_o.predict_taken         <= predict_taken;
            id_in_o.predict_pc            <= predict_pc;
            valid_o                       <= 1'b1;
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage, directly upstream of the decode stage.
- Holds the PC and reads instruction memory combinationally.
- Predecodes control-flow class and predicts the next PC using a direct-mapped BTB with 2-bit counters.
- Registers an id_stage_in_t packet for decode; accepts stall/flush from the HDU, redirects and predictor updates from execute.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2.
- NOP_INST, 32'h0000_0013, instruction inserted on flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr_o  out  32  fetch address; always equals the PC register.
- imem_inst_i  in  32  instruction at imem_addr_o, same cycle (combinational read).
- stall_i  in  1  hold PC and the IF/ID register.
- flush_i  in  1  replace the IF/ID contents with a bubble.
- redirect_i  in  1  misprediction; load redirect_pc_i into PC.
- redirect_pc_i  in  32  corrected PC.
- upd_en_i  in  1  BTB update strobe from execute.
- upd_pc_i  in  32  PC of the resolved control-flow instruction.
- upd_target_i  in  32  resolved target.
- upd_taken_i  in  1  resolved direction.
- upd_is_cond_i  in  1  resolved instruction is a conditional branch; otherwise JAL/JALR.
- id_in_o  out  132  id_stage_pkg::id_stage_in_t packet: inst, pc, pc4, is_conditional_branch, is_jalr, is_jal, predict_taken, predict_pc.
- valid_o  out  1  id_in_o holds a real fetched instruction.

Behaviour:
- Reset is synchronous and active-high on rst; single clock clk.
- Reset values:
  - PC = RESET_PC.
  - id_in_o: inst = NOP_INST, pc = 0, pc4 = 0, predict_pc = 0, all flags 0.
  - valid_o = 0.
  - All BTB valid bits cleared; BTB targets, tags and counters are don't-care.
  - A reset asserted mid-operation discards any in-flight fetch.
- Predecode of imem_inst_i[6:0] (combinational):
  - BRANCH → is_conditional_branch.
  - JAL → is_jal.
  - JALR → is_jalr.
  - All others → no flag set.
- BTB indexing:
  - Index = pc[IDX+1:2], where IDX = log2(BTB_ENTRIES).
  - Tag = pc[31:IDX+2].
  - Each entry holds valid, tag, 32-bit target and a 2-bit counter.
- Prediction (combinational on the current PC):
  - hit = valid && tag match.
  - predict_taken = hit && (is_jal || is_jalr || (is_conditional_branch && ctr[1])).
  - Non-control-flow instructions never predict taken, even on a hit.
  - predict_pc = predict_taken ? target : pc + 4.
- Next-PC priority: rst > redirect_i > stall_i > predict_pc.
  - Redirect overrides a simultaneous stall.
- IF/ID register priority: rst > flush_i > stall_i > capture.
  - Flush loads the bubble (reset values) with valid_o = 0.
  - Flush wins over a simultaneous stall.
  - Capture loads inst, pc, pc + 4, the predecode flags, predict_taken and predict_pc, with valid_o = 1.
- A redirect does not itself flush; the HDU asserts flush_i in the same cycle.
- BTB update, on the rising edge when upd_en_i = 1:
  - Conditional branch, tag hit: counter saturating +1 if taken, -1 if not taken; target written only when taken.
  - Conditional branch, miss, taken: allocate the entry (overwriting any occupant) with ctr = 2'b10 and the given target.
  - Conditional branch, miss, not taken: no change.
  - JAL/JALR: allocate or overwrite with ctr = 2'b11 and the given target.
  - Counter saturates at 00 and 11; no wrap.
  - No read bypass: an update is visible to prediction from the next cycle.
  - A simultaneous read and update of the same index returns the old contents.
- PC arithmetic is modulo 2^32; pc4 wraps 0xFFFF_FFFC → 0.

Test Plan:
- Reset release, imem returns addi at every address → PC sequence 0, 4, 8; id_in_o.pc lags by one cycle; valid_o rises one cycle after rst falls; predict_taken = 0.
- Branch at 0x40 (opcode 1100011) with no BTB entry → predict_taken = 0, predict_pc = 0x44. Then update (0x40, target 0x100, taken, cond) → refetch of 0x40 gives ctr = 10, predict_taken = 1, predict_pc = 0x100, next PC = 0x100.
- Counter saturation: two not-taken updates to 0x40 from ctr = 10 → ctr = 00, predict_taken = 0. A third not-taken update keeps 00; one taken update → 01, still not taken.
- JAL at 0x80, update target 0x200 → next fetch of 0x80 predicts 0x200. An aliasing PC 0x80 + 4·BTB_ENTRIES misses on tag → predict_pc = PC + 4.
- stall_i held 3 cycles → PC and id_in_o unchanged. stall_i with redirect_i = 1 (pc 0x300) → PC = 0x300 next cycle. flush_i with stall_i → inst = 0x0000_0013, valid_o = 0.
- rst asserted mid-stream after a BTB allocation → PC = RESET_PC, valid_o = 0; a previously hitting branch now predicts not taken.
